// File: rtl/cpu_writeback_unit.sv
`default_nettype none
// ============================================================================
// Module      : cpu_writeback_unit
// Description : Arbitrates single-cycle ALU results and buffered load results
//               onto the register file's single write port and tracks which
//               registers still wait on an outstanding load.
// Revision    : 1.0 - initial release
// ============================================================================
module cpu_writeback_unit #(
    parameter bit MORE_REGISTERS  = 1'b1,
    parameter int LOAD_FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        issue_load_valid,
    input  logic [4:0]  issue_load_rd,
    input  logic [4:0]  query_rs1,
    input  logic [4:0]  query_rs2,
    output logic        query_busy1,
    output logic        query_busy2,
    input  logic        alu_valid,
    input  logic [4:0]  alu_rd,
    input  logic [31:0] alu_data,
    input  logic        mem_valid,
    output logic        mem_ready,
    input  logic [4:0]  mem_rd,
    input  logic [31:0] mem_data,
    output logic        rf_wr,
    output logic [4:0]  rf_addr_wr,
    output logic [31:0] rf_data_wr,
    output logic        wb_idle
);

    localparam int                 c_PTR_W = (LOAD_FIFO_DEPTH > 1) ? $clog2(LOAD_FIFO_DEPTH) : 1;
    localparam int                 c_CNT_W = c_PTR_W + 1;
    localparam logic [c_CNT_W-1:0] c_DEPTH = c_CNT_W'(LOAD_FIFO_DEPTH);

    // Destination is writable: never x0, and never x16-x31 on the reduced file.
    function automatic logic f_rd_valid(input logic [4:0] rd);
        return (rd != 5'd0) && (MORE_REGISTERS || !rd[4]);
    endfunction

    // Load-result buffer storage and bookkeeping
    logic [4:0]         r_fifo_rd   [LOAD_FIFO_DEPTH];
    logic [31:0]        r_fifo_data [LOAD_FIFO_DEPTH];
    logic [c_PTR_W-1:0] r_head;
    logic [c_PTR_W-1:0] r_tail;
    logic [c_CNT_W-1:0] r_count;

    // Output stage and scoreboard
    logic               r_rf_wr;
    logic [4:0]         r_rf_addr;
    logic [31:0]        r_rf_data;
    logic               r_from_fifo;
    logic [31:0]        r_busy;

    logic               w_fifo_empty;
    logic               w_mem_ready;
    logic               w_push;
    logic               w_alu_sel;
    logic               w_pop;
    logic [31:0]        w_set_mask;
    logic [31:0]        w_clr_mask;

    assign w_fifo_empty = (r_count == '0);
    // Ready depends only on occupancy so a full buffer refuses a push even if
    // it pops in the same cycle.
    assign w_mem_ready  = !rst && (r_count < c_DEPTH);
    // Transfers to an invalid destination are consumed but never stored.
    assign w_push       = mem_valid && w_mem_ready && f_rd_valid(mem_rd);
    assign w_alu_sel    = alu_valid && f_rd_valid(alu_rd);
    assign w_pop        = !w_alu_sel && !w_fifo_empty;

    // A load-sourced commit releases its register at the end of the write cycle;
    // a new issue to the same register on that edge keeps it busy.
    assign w_set_mask   = (issue_load_valid && f_rd_valid(issue_load_rd))
                          ? (32'd1 << issue_load_rd) : 32'd0;
    assign w_clr_mask   = (r_rf_wr && r_from_fifo) ? (32'd1 << r_rf_addr) : 32'd0;

    // Load-result buffer: pointer and occupancy update
    always_ff @(posedge clk) begin
        if (rst) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_tail <= r_tail + c_PTR_W'(1);
            end
            if (w_pop) begin
                r_head <= r_head + c_PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_CNT_W'(1);
                2'b01:   r_count <= r_count - c_CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Load-result buffer: data storage, contents are don't-care while empty
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo_rd[r_tail]   <= mem_rd;
            r_fifo_data[r_tail] <= mem_data;
        end
    end

    // Write-port stage: ALU first, then the oldest buffered load, else idle
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rf_wr     <= 1'b0;
            r_rf_addr   <= 5'd0;
            r_rf_data   <= 32'd0;
            r_from_fifo <= 1'b0;
        end else if (w_alu_sel) begin
            r_rf_wr     <= 1'b1;
            r_rf_addr   <= alu_rd;
            r_rf_data   <= alu_data;
            r_from_fifo <= 1'b0;
        end else if (w_pop) begin
            r_rf_wr     <= 1'b1;
            r_rf_addr   <= r_fifo_rd[r_head];
            r_rf_data   <= r_fifo_data[r_head];
            r_from_fifo <= 1'b1;
        end else begin
            r_rf_wr     <= 1'b0;
            r_from_fifo <= 1'b0;
        end
    end

    // Scoreboard of registers awaiting a load result; x0 never marked busy
    always_ff @(posedge clk) begin
        if (rst) begin
            r_busy <= 32'd0;
        end else begin
            r_busy <= ((r_busy & ~w_clr_mask) | w_set_mask) & ~32'd1;
        end
    end

    assign query_busy1 = r_busy[query_rs1];
    assign query_busy2 = r_busy[query_rs2];
    assign mem_ready   = w_mem_ready;
    assign rf_wr       = r_rf_wr;
    assign rf_addr_wr  = r_rf_addr;
    assign rf_data_wr  = r_rf_data;
    assign wb_idle     = w_fifo_empty && !r_rf_wr && (r_busy == 32'd0);

endmodule
`default_nettype wire

// File: tb/tb_cpu_writeback_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_cpu_writeback_unit
// Description : Self-checking bench for cpu_writeback_unit: directed scenarios
//               plus randomized traffic against a queue-based reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cpu_writeback_unit;

    localparam int c_DEPTH = 2;

    logic        clk;
    logic        rst;
    logic        issue_load_valid;
    logic [4:0]  issue_load_rd;
    logic [4:0]  query_rs1;
    logic [4:0]  query_rs2;
    logic        alu_valid;
    logic [4:0]  alu_rd;
    logic [31:0] alu_data;
    logic        mem_valid;
    logic [4:0]  mem_rd;
    logic [31:0] mem_data;

    logic        query_busy1, query_busy2, mem_ready, rf_wr, wb_idle;
    logic [4:0]  rf_addr_wr;
    logic [31:0] rf_data_wr;

    logic        s_query_busy1, s_query_busy2, s_mem_ready, s_rf_wr, s_wb_idle;
    logic [4:0]  s_rf_addr_wr;
    logic [31:0] s_rf_data_wr;

    int n_checks = 0;
    int n_pass   = 0;

    cpu_writeback_unit #(.MORE_REGISTERS(1'b1), .LOAD_FIFO_DEPTH(c_DEPTH)) dut (
        .clk(clk), .rst(rst),
        .issue_load_valid(issue_load_valid), .issue_load_rd(issue_load_rd),
        .query_rs1(query_rs1), .query_rs2(query_rs2),
        .query_busy1(query_busy1), .query_busy2(query_busy2),
        .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_rd(mem_rd), .mem_data(mem_data),
        .rf_wr(rf_wr), .rf_addr_wr(rf_addr_wr), .rf_data_wr(rf_data_wr),
        .wb_idle(wb_idle)
    );

    cpu_writeback_unit #(.MORE_REGISTERS(1'b0), .LOAD_FIFO_DEPTH(c_DEPTH)) dut15 (
        .clk(clk), .rst(rst),
        .issue_load_valid(issue_load_valid), .issue_load_rd(issue_load_rd),
        .query_rs1(query_rs1), .query_rs2(query_rs2),
        .query_busy1(s_query_busy1), .query_busy2(s_query_busy2),
        .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data),
        .mem_valid(mem_valid), .mem_ready(s_mem_ready), .mem_rd(mem_rd), .mem_data(mem_data),
        .rf_wr(s_rf_wr), .rf_addr_wr(s_rf_addr_wr), .rf_data_wr(s_rf_data_wr),
        .wb_idle(s_wb_idle)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ------------------------------------------------------------------
    // Reference model of the full-register-file instance: a queue of pending
    // load results, the last write presented to the register file, and a set
    // of registers waiting for load data.
    // ------------------------------------------------------------------
    int          m_q_rd[$];
    logic [31:0] m_q_data[$];
    bit          m_wr = 0;
    bit          m_fifo = 0;
    logic [4:0]  m_addr = 0;
    logic [31:0] m_data = 0;
    logic [31:0] m_busy = 0;
    bit          m_acc_ok;

    function automatic bit rd_ok(input logic [4:0] rd);
        return rd != 5'd0;
    endfunction

    function automatic bit model_ready();
        return !rst && (m_q_rd.size() < c_DEPTH);
    endfunction

    // Model advances on each rising edge using the inputs held during the cycle.
    always @(posedge clk) begin
        m_acc_ok = model_ready();
        if (rst) begin
            m_q_rd.delete();
            m_q_data.delete();
            m_wr = 0; m_fifo = 0; m_addr = 0; m_data = 0; m_busy = 0;
        end else begin
            if (m_wr && m_fifo) m_busy[m_addr] = 1'b0;
            if (issue_load_valid && rd_ok(issue_load_rd)) m_busy[issue_load_rd] = 1'b1;
            if (alu_valid && rd_ok(alu_rd)) begin
                m_wr = 1; m_fifo = 0; m_addr = alu_rd; m_data = alu_data;
            end else if (m_q_rd.size() > 0) begin
                m_wr = 1; m_fifo = 1;
                m_addr = 5'(m_q_rd.pop_front());
                m_data = m_q_data.pop_front();
            end else begin
                m_wr = 0; m_fifo = 0;
            end
            if (mem_valid && m_acc_ok && rd_ok(mem_rd)) begin
                m_q_rd.push_back(int'(mem_rd));
                m_q_data.push_back(mem_data);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        issue_load_valid = 0; issue_load_rd = 0;
        alu_valid = 0; alu_rd = 0; alu_data = 0;
        mem_valid = 0; mem_rd = 0; mem_data = 0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1;
        tick();
        tick();
        rst = 0;
    endtask

    task automatic test_reset();
        idle_inputs();
        query_rs1 = 5; query_rs2 = 0;
        rst = 1;
        tick();
        tick();
        #1;
        n_checks++; if (mem_ready !== 1'b0) $display("FAIL reset_mem_ready_low: got %b want 0", mem_ready); else n_pass++;
        n_checks++; if ({rf_wr, rf_addr_wr, rf_data_wr} !== 38'd0)
            $display("FAIL reset_outputs: got wr=%b addr=%0d data=%h want all zero", rf_wr, rf_addr_wr, rf_data_wr); else n_pass++;
        rst = 0;
        #1;
        n_checks++; if (mem_ready !== 1'b1) $display("FAIL idle_mem_ready: got %b want 1", mem_ready); else n_pass++;
        n_checks++; if (wb_idle !== 1'b1) $display("FAIL idle_wb_idle: got %b want 1", wb_idle); else n_pass++;
        n_checks++; if (query_busy1 !== 1'b0) $display("FAIL idle_busy_x5: got %b want 0", query_busy1); else n_pass++;
        tick();
        n_checks++; if (rf_wr !== 1'b0) $display("FAIL idle_rf_wr: got %b want 0", rf_wr); else n_pass++;
    endtask

    task automatic test_alu();
        alu_valid = 1; alu_rd = 7; alu_data = 32'hDEADBEEF;
        tick();
        alu_rd = 0; alu_data = 32'h1111_2222;
        #1;
        n_checks++; if ({rf_wr, rf_addr_wr, rf_data_wr} !== {1'b1, 5'd7, 32'hDEADBEEF})
            $display("FAIL alu_write: got wr=%b addr=%0d data=%h want 1/7/deadbeef", rf_wr, rf_addr_wr, rf_data_wr); else n_pass++;
        tick();
        alu_valid = 0;
        #1;
        n_checks++; if ({rf_wr, rf_addr_wr, rf_data_wr} !== {1'b0, 5'd7, 32'hDEADBEEF})
            $display("FAIL alu_x0_dropped: got wr=%b addr=%0d data=%h want 0/7/deadbeef", rf_wr, rf_addr_wr, rf_data_wr); else n_pass++;
        n_checks++; if (wb_idle !== 1'b1) $display("FAIL alu_idle_after: got %b want 1", wb_idle); else n_pass++;
    endtask

    task automatic test_load_roundtrip();
        query_rs1 = 3;
        issue_load_valid = 1; issue_load_rd = 3;
        tick();
        issue_load_valid = 0;
        for (int c = 1; c <= 4; c++) begin
            #1;
            n_checks++; if (query_busy1 !== 1'b1) $display("FAIL load_busy_cycle%0d: got %b want 1", c, query_busy1); else n_pass++;
            tick();
        end
        mem_valid = 1; mem_rd = 3; mem_data = 32'h12345678;
        #1;
        n_checks++; if (mem_ready !== 1'b1) $display("FAIL load_mem_ready: got %b want 1", mem_ready); else n_pass++;
        tick();
        mem_valid = 0;
        #1;
        n_checks++; if (rf_wr !== 1'b0) $display("FAIL load_no_early_write: got %b want 0", rf_wr); else n_pass++;
        tick();
        #1;
        n_checks++; if ({rf_wr, rf_addr_wr, rf_data_wr} !== {1'b1, 5'd3, 32'h12345678})
            $display("FAIL load_write_cycle7: got wr=%b addr=%0d data=%h want 1/3/12345678", rf_wr, rf_addr_wr, rf_data_wr); else n_pass++;
        n_checks++; if (query_busy1 !== 1'b1) $display("FAIL load_busy_cycle7: got %b want 1", query_busy1); else n_pass++;
        tick();
        #1;
        n_checks++; if (query_busy1 !== 1'b0) $display("FAIL load_busy_cycle8: got %b want 0", query_busy1); else n_pass++;
        n_checks++; if (wb_idle !== 1'b1) $display("FAIL load_idle_cycle8: got %b want 1", wb_idle); else n_pass++;
    endtask

    task automatic test_contention();
        logic [4:0] exp_addr [3];
        exp_addr[0] = 10; exp_addr[1] = 11; exp_addr[2] = 12;
        mem_valid = 1; mem_rd = 4; mem_data = 32'h0000_00A4;
        tick();
        mem_valid = 0;
        alu_valid = 1; alu_rd = 9; alu_data = 32'h91;
        tick();
        alu_data = 32'h92;
        #1;
        n_checks++; if ({rf_wr, rf_addr_wr, rf_data_wr} !== {1'b1, 5'd9, 32'h91})
            $display("FAIL cont_first_alu: got wr=%b addr=%0d data=%h want 1/9/91", rf_wr, rf_addr_wr, rf_data_wr); else n_pass++;
        tick();
        alu_valid = 0;
        #1;
        n_checks++; if ({rf_wr, rf_addr_wr, rf_data_wr} !== {1'b1, 5'd9, 32'h92})
            $display("FAIL cont_second_alu: got wr=%b addr=%0d data=%h want 1/9/92", rf_wr, rf_addr_wr, rf_data_wr); else n_pass++;
        tick();
        #1;
        n_checks++; if ({rf_wr, rf_addr_wr, rf_data_wr} !== {1'b1, 5'd4, 32'hA4})
            $display("FAIL cont_delayed_load: got wr=%b addr=%0d data=%h want 1/4/a4", rf_wr, rf_addr_wr, rf_data_wr); else n_pass++;
        tick();
        // Fill the buffer while ALU traffic starves it.
        alu_valid = 1; alu_rd = 9;
        mem_valid = 1; mem_rd = 10; mem_data = 32'h100;
        tick();
        mem_rd = 11; mem_data = 32'h110;
        tick();
        alu_valid = 0;
        mem_rd = 12; mem_data = 32'h120;
        #1;
        n_checks++; if (mem_ready !== 1'b0) $display("FAIL cont_full_not_ready: got %b want 0", mem_ready); else n_pass++;
        tick();
        #1;
        n_checks++; if (mem_ready !== 1'b1) $display("FAIL cont_ready_after_pop: got %b want 1", mem_ready); else n_pass++;
        for (int k = 0; k < 3; k++) begin
            n_checks++; if ({rf_wr, rf_addr_wr, rf_data_wr} !== {1'b1, exp_addr[k], 32'h100 + 32'(16 * k)})
                $display("FAIL cont_drain%0d: got wr=%b addr=%0d data=%h want 1/%0d/%h", k, rf_wr, rf_addr_wr, rf_data_wr,
                         exp_addr[k], 32'h100 + 32'(16 * k)); else n_pass++;
            tick();
            mem_valid = 0;
            #1;
        end
        n_checks++; if (rf_wr !== 1'b0) $display("FAIL cont_drained: got %b want 0", rf_wr); else n_pass++;
    endtask

    task automatic test_small_regs();
        do_reset();
        query_rs1 = 20;
        issue_load_valid = 1; issue_load_rd = 20;
        tick();
        issue_load_valid = 0;
        mem_valid = 1; mem_rd = 20; mem_data = 32'h2020;
        #1;
        n_checks++; if (s_query_busy1 !== 1'b0) $display("FAIL small_no_busy: got %b want 0", s_query_busy1); else n_pass++;
        n_checks++; if (s_mem_ready !== 1'b1) $display("FAIL small_mem_ready: got %b want 1", s_mem_ready); else n_pass++;
        tick();
        mem_valid = 0;
        alu_valid = 1; alu_rd = 20; alu_data = 32'hA;
        #1;
        n_checks++; if (s_wb_idle !== 1'b1) $display("FAIL small_mem_dropped: got wb_idle=%b want 1", s_wb_idle); else n_pass++;
        tick();
        alu_valid = 0;
        #1;
        n_checks++; if (s_rf_wr !== 1'b0) $display("FAIL small_alu_dropped: got %b want 0", s_rf_wr); else n_pass++;
        n_checks++; if ({rf_wr, rf_addr_wr, rf_data_wr} !== {1'b1, 5'd20, 32'hA})
            $display("FAIL full_alu_x20: got wr=%b addr=%0d data=%h want 1/20/a", rf_wr, rf_addr_wr, rf_data_wr); else n_pass++;
        tick();
        tick();
    endtask

    task automatic test_collision();
        do_reset();
        query_rs1 = 5;
        issue_load_valid = 1; issue_load_rd = 5;
        tick();
        issue_load_valid = 0;
        mem_valid = 1; mem_rd = 5; mem_data = 32'h55;
        #1;
        n_checks++; if (query_busy1 !== 1'b1) $display("FAIL coll_busy_set: got %b want 1", query_busy1); else n_pass++;
        tick();
        mem_valid = 0;
        tick();
        issue_load_valid = 1; issue_load_rd = 5;
        #1;
        n_checks++; if ({rf_wr, rf_addr_wr} !== {1'b1, 5'd5}) $display("FAIL coll_commit: got wr=%b addr=%0d want 1/5", rf_wr, rf_addr_wr); else n_pass++;
        tick();
        issue_load_valid = 0;
        #1;
        n_checks++; if (query_busy1 !== 1'b1) $display("FAIL coll_set_wins: got %b want 1", query_busy1); else n_pass++;
        tick();
        n_checks++; if (query_busy1 !== 1'b1) $display("FAIL coll_still_busy: got %b want 1", query_busy1); else n_pass++;
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 400; c++) begin
            rst              = ($urandom_range(0, 99) == 0);
            issue_load_valid = ($urandom_range(0, 3) == 0);
            issue_load_rd    = 5'($urandom_range(0, 31));
            alu_valid        = ($urandom_range(0, 2) == 0);
            alu_rd           = 5'($urandom_range(0, 31));
            alu_data         = $urandom;
            mem_valid        = ($urandom_range(0, 1) == 0);
            mem_rd           = 5'($urandom_range(0, 31));
            mem_data         = $urandom;
            query_rs1        = 5'($urandom_range(0, 31));
            query_rs2        = 5'($urandom_range(0, 31));
            #1;
            n_checks++; if ({rf_wr, rf_addr_wr, rf_data_wr} !== {m_wr, m_addr, m_data})
                $display("FAIL rand_wport c%0d: got %b/%0d/%h want %b/%0d/%h", c, rf_wr, rf_addr_wr, rf_data_wr, m_wr, m_addr, m_data); else n_pass++;
            n_checks++; if (mem_ready !== model_ready())
                $display("FAIL rand_mem_ready c%0d: got %b want %b", c, mem_ready, model_ready()); else n_pass++;
            n_checks++; if ({query_busy1, query_busy2} !== {m_busy[query_rs1], m_busy[query_rs2]})
                $display("FAIL rand_busy c%0d: got %b%b want %b%b", c, query_busy1, query_busy2, m_busy[query_rs1], m_busy[query_rs2]); else n_pass++;
            n_checks++; if (wb_idle !== (m_q_rd.size() == 0 && !m_wr && m_busy == 32'd0))
                $display("FAIL rand_idle c%0d: got %b want %b", c, wb_idle, (m_q_rd.size() == 0 && !m_wr && m_busy == 32'd0)); else n_pass++;
            tick();
        end
        rst = 0;
        idle_inputs();
    endtask

    initial begin
        idle_inputs();
        query_rs1 = 0; query_rs2 = 0;
        rst = 1;
        #2;
        test_reset();
        test_alu();
        test_load_roundtrip();
        test_contention();
        test_small_regs();
        test_collision();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/cpu_writeback_unit.md
# cpu_writeback_unit

Writer-side companion to the CPU register file: collects results from the single-cycle ALU path and the variable-latency load path, arbitrates them onto the register file's single write port, and keeps a per-register scoreboard of outstanding load destinations for decode-stage stall decisions. Sits between execute/memory stages and the register file write port (`wr`, `addr_wr`, `data_wr`).

## Interface
- `MORE_REGISTERS`, 1'b1 — 1: x1–x31 writable; 0: x1–x15 only, destinations with bit 4 set are dropped everywhere.
- `LOAD_FIFO_DEPTH`, 2 — load-result buffer depth, power of two, ≥2.

- `clk` in 1 — single clock, all state on rising edge.
- `rst` in 1 — synchronous, active-high reset.
- `issue_load_valid` in 1 — decode issuing a load this cycle.
- `issue_load_rd` in 5 — its destination register.
- `query_rs1`, `query_rs2` in 5 each — decode source registers.
- `query_busy1`, `query_busy2` out 1 each — combinational scoreboard lookup.
- `alu_valid` in 1 — ALU result present (always accepted, no ready).
- `alu_rd` in 5, `alu_data` in 32 — ALU destination/result.
- `mem_valid` in 1, `mem_ready` out 1 — load-result handshake.
- `mem_rd` in 5, `mem_data` in 32 — load destination/result.
- `rf_wr` out 1, `rf_addr_wr` out 5, `rf_data_wr` out 32 — to register file write port.
- `wb_idle` out 1 — FIFO empty, `rf_wr` low, scoreboard all-zero.

## Operation
- Valid destination: rd ≠ 0 and (MORE_REGISTERS or rd[4] = 0). Invalid destinations never write, never set/clear scoreboard.
- Load FIFO: push on `mem_valid && mem_ready` with valid rd; transfer with invalid rd is consumed and discarded. `mem_ready = !rst && count < LOAD_FIFO_DEPTH` (combinational, independent of `mem_valid`).
- Output stage (registered), selected each cycle, priority order:
  1. `alu_valid` with valid rd → load {1, alu_rd, alu_data}.
  2. else FIFO non-empty → pop head into output stage.
  3. else `rf_wr` ← 0; `rf_addr_wr`/`rf_data_wr` hold.
- ALU with invalid rd does not block FIFO drain. Continuous ALU traffic may starve the FIFO; no fairness required.
- Scoreboard: 32 bits, bit 0 hardwired 0.
  - Set at edge when `issue_load_valid` with valid rd.
  - Clear at end of a cycle in which `rf_wr` is high, the output came from the FIFO, and `rf_addr_wr` matches.
  - Set and clear same register same edge → set wins.
  - ALU write to a busy register: performed, scoreboard unchanged (decode must prevent; not an error).
- `query_busyN` = scoreboard[query_rsN]; rs = 0 → 0.
- Push and pop same cycle with FIFO full: pop happens, push refused (`mem_ready` already 0).

## Timing
- Reset (edge with `rst` = 1): FIFO empty, scoreboard zero, `rf_wr` = 0, `rf_addr_wr` = 0, `rf_data_wr` = 0, `mem_ready` = 0 while `rst` high, 1 next cycle; `wb_idle` = 1 after reset. Reset mid-transfer discards all buffered results.
- ALU accepted cycle N → `rf_wr` high cycle N+1, register file updated end of N+1.
- Load accepted cycle N, no ALU contention → FIFO non-empty N+1, popped end of N+1, `rf_wr` high N+2, scoreboard bit clears end of N+2, `query_busy` low N+3 (register file already holds new value; no bypass).
- Each cycle of ALU contention delays the pop by one cycle.
- Sustained throughput: one write per cycle.

## Test plan
- Reset then idle: `rf_wr` = 0, `mem_ready` = 1, `wb_idle` = 1, `query_busy1` for rs1 = 5 is 0.
- ALU only: `alu_valid`, rd = 7, data 0xDEADBEEF in cycle N → `rf_wr` = 1, addr 7, data 0xDEADBEEF in N+1; rd = 0 → no write.
- Load round trip: issue load rd = 3 cycle 0 → `query_busy1`(3) = 1 from cycle 1; mem result rd = 3, 0x12345678 at cycle 5 → write in cycle 7, busy = 0 in cycle 8.
- Contention: mem result rd = 4 at cycle N, `alu_valid` rd = 9 at N+1 and N+2 → writes x9, x9, then x4 in N+4; FIFO fills with depth 2 → `mem_ready` drops, third result held until pop.
- MORE_REGISTERS = 0: load issue rd = 20 → no scoreboard set; mem result rd = 20 accepted, dropped; ALU rd = 20 → no `rf_wr`.
- Set/clear collision: FIFO write to x5 committing in same cycle as new issue of load rd = 5 → x5 remains busy.
